uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// Optional build macro UART_ARB_ID_HEADER_EN sends an ID header frame before each data byte.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBITS   = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DBITS-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  busy,
  output logic                  tx_start,
  output logic [DBITS-1:0]      tx_din,
  input  logic                  tx_done,
  output logic [2:0]            state
);

  // Handshake: a requester holds req (level) until it sees its one-cycle ack;
  // the transmitter gets a one-cycle tx_start per frame and answers with a one-cycle tx_done.
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT      = 3'd2,
`ifdef UART_ARB_ID_HEADER_EN
    HDR_START = 3'd4,
    HDR_WAIT  = 3'd5,
`endif
    DONE      = 3'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   last_q, win_q, win;
  logic            err_q;
  logic            found;
  int              idx;
  logic            waiting;
  logic            cnt_max;
  logic            tmo;
  logic            frame_begin;
`ifdef UART_ARB_ID_HEADER_EN
  logic [DBITS-1:0] data_q;
`endif

  // Rotating priority: search upward from the requester after the last winner.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
`ifdef UART_ARB_ID_HEADER_EN
    waiting     = (state_q == WAIT) || (state_q == HDR_WAIT);
    frame_begin = (state_d == START) || (state_d == HDR_START);
`else
    waiting     = (state_q == WAIT);
    frame_begin = (state_d == START);
`endif
    cnt_max = (cnt_q == CW'(TIMEOUT - 1));
    // A tx_done landing on the last allowed cycle still counts as a normal finish.
    tmo     = waiting && cnt_max && !tx_done;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
`ifdef UART_ARB_ID_HEADER_EN
          state_d = HDR_START;
`else
          state_d = START;
`endif
        end
      end
`ifdef UART_ARB_ID_HEADER_EN
      HDR_START: state_d = HDR_WAIT;
      HDR_WAIT: begin
        if (tx_done)      state_d = START;
        else if (cnt_max) state_d = DONE;
      end
`endif
      START: state_d = WAIT;
      WAIT:  if (tx_done || cnt_max) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
`ifdef UART_ARB_ID_HEADER_EN
    tx_start = (state_q == START) || (state_q == HDR_START);
`else
    tx_start = (state_q == START);
`endif
    ack   = (state_q == DONE) ? grant : '0;
    err   = (state_q == DONE) && err_q;
    state = state_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      grant  <= '0;
      win_q  <= '0;
      last_q <= IW'(NREQ - 1);
      tx_din <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
`ifdef UART_ARB_ID_HEADER_EN
      data_q <= '0;
`endif
    end else begin
      if (frame_begin || state_d == IDLE || state_d == DONE) cnt_q <= '0;
      else                                                   cnt_q <= cnt_q + CW'(1);

      if (state_q == IDLE && |req) begin
        grant <= NREQ'(1) << win;
        win_q <= win;
        err_q <= 1'b0;
`ifdef UART_ARB_ID_HEADER_EN
        data_q <= req_data[int'(win)*DBITS +: DBITS];
        tx_din <= {4'b1010, (DBITS-4)'(win)};
`else
        tx_din <= req_data[int'(win)*DBITS +: DBITS];
`endif
      end

`ifdef UART_ARB_ID_HEADER_EN
      if (state_q == HDR_WAIT && tx_done) tx_din <= data_q;
`endif

      if (tmo) err_q <= 1'b1;

      if (state_q == DONE) begin
        grant  <= '0;
        last_q <= win_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-plus-random bench for uart_tx_arbiter with a rotation/timeout reference model.
// Expected frames per grant follow UART_ARB_ID_HEADER_EN when it is defined.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DBITS   = 8;
  localparam int TIMEOUT = 16;

  logic                  PCLK = 1'b0;
  logic                  PRESETn;
  logic [NREQ-1:0]       req;
  logic [NREQ*DBITS-1:0] req_data;
  logic [NREQ-1:0]       grant, ack;
  logic                  err, busy, tx_start, tx_done;
  logic [DBITS-1:0]      tx_din;
  logic [2:0]            state_dbg;

  int tests = 0;
  int fails = 0;
  int last_m = NREQ - 1;
  logic [DBITS-1:0] exp_q[$];

  uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err), .busy(busy), .tx_start(tx_start),
    .tx_din(tx_din), .tx_done(tx_done), .state(state_dbg)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (last_m + i) % NREQ;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic wait_cycles(input int n, input logic [DBITS-1:0] cur);
    for (int c = 0; c < n; c++) begin
      @(negedge PCLK);
      tx_done = 1'b0;
      check("no_restart", tx_start, 0);
      check("early_ack", ack, 0);
      check("tx_din_stable", tx_din, cur);
    end
  endtask

  // One complete service; d==0 means the transmitter never answers that frame.
  task automatic serve(input int d0, input int d1, input bit scramble, input logic [NREQ-1:0] req_after);
    int w;
    int dl[$];
    logic [NREQ-1:0] oh;
    logic [DBITS-1:0] cur;
    bit to;
    w  = pick(req);
    oh = NREQ'(1) << w;
    exp_q = {};
    dl    = {};
`ifdef UART_ARB_ID_HEADER_EN
    exp_q.push_back({4'hA, 4'(w)});
    dl.push_back(d0);
    exp_q.push_back(req_data[w*DBITS +: DBITS]);
    dl.push_back(d1);
`else
    exp_q.push_back(req_data[w*DBITS +: DBITS]);
    dl.push_back(d0);
`endif
    to = 1'b0;
    while (exp_q.size() > 0 && !to) begin
      @(negedge PCLK);
      tx_done = 1'b0;
      cur = exp_q.pop_front();
      check("tx_start", tx_start, 1);
      check("grant", grant, oh);
      check("tx_din", tx_din, cur);
      check("busy", busy, 1);
      if (scramble) begin
        req      = NREQ'($urandom);
        req_data = $urandom;
      end
      if (dl[0] == 0) begin
        wait_cycles(TIMEOUT - 1, cur);
        to = 1'b1;
      end else begin
        wait_cycles(dl[0], cur);
        tx_done = 1'b1;
      end
      dl.delete(0);
    end
    @(negedge PCLK);
    tx_done = 1'b0;
    check("ack", ack, oh);
    check("err", err, to);
    check("done_busy", busy, 1);
    check("done_tx_start", tx_start, 0);
    last_m   = w;
    req      = req_after;
    req_data = $urandom;
    @(negedge PCLK);
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("idle_ack", ack, 0);
    check("idle_err", err, 0);
  endtask

  initial begin
    req = '0; req_data = '0; tx_done = 1'b0; PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_din", tx_din, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("no_req_idle", busy, 0);

    // All requesters held: rotation 0,1,2,3,0 from reset.
    req = '1;
    req_data = $urandom;
    for (int i = 0; i < 5; i++)
      serve($urandom_range(1, TIMEOUT - 1), $urandom_range(1, TIMEOUT - 1), 1'b0,
            (i == 4) ? '0 : '1);

    req = 4'b0001;
    req_data = $urandom;
    req_data[7:0] = 8'h55;
    serve(10, 10, 1'b0, '0);

    req = 4'b0010;
    serve(0, 0, 1'b0, '0);

    req = 4'b1000;
    serve(TIMEOUT - 1, TIMEOUT - 1, 1'b0, '0);

    req = 4'b0100;
    req_data[23:16] = 8'h3C;
    serve(4, 6, 1'b0, '0);

`ifdef UART_ARB_ID_HEADER_EN
    req = 4'b0001;
    serve(5, 0, 1'b0, '0);
`endif

    // Stray tx_done while idle must not wake the arbiter.
    tx_done = 1'b1;
    @(negedge PCLK);
    tx_done = 1'b0;
    check("stray_busy", busy, 0);
    check("stray_tx_start", tx_start, 0);
    @(negedge PCLK);
    check("stray_busy2", busy, 0);

    for (int i = 0; i < 20; i++) begin
      req      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_data = $urandom;
      serve($urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), 1'b1, '0);
    end

    // Reset in the middle of a service drops it without an ack.
    req = 4'b0100;
    req_data = $urandom;
    @(negedge PCLK);
    check("pre_rst_start", tx_start, 1);
    check("pre_rst_grant", grant, NREQ'(1) << pick(req));
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_din", tx_din, 0);
    @(negedge PCLK);
    check("rst_hold_ack", ack, 0);
    PRESETn = 1'b1;
    last_m  = NREQ - 1;
    serve(3, 3, 1'b0, '0);

    req = 4'b1010;
    serve(7, 2, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
